// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall controller bus.
// Groups the pipeline-facing signals of hazard_stall_controller.
//   Toward the controller: IF/ID source specifiers and read flags, ID/EX
//   destination and load flag, EX branch resolution, data-memory busy and
//   the statistics clear.
//   From the controller: PC / IF-ID / pipe enables, IF-ID and ID-EX
//   flushes, saturating stall counter and the FSM state bit.
// Modports: slave = controller side, master = pipeline / testbench side.
interface hazard_stall_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] rs1__IF_ID;
  logic [REG_W-1:0] rs2__IF_ID;
  logic             uses_rs1__IF_ID;
  logic             uses_rs2__IF_ID;
  logic [REG_W-1:0] rd__ID_EX;
  logic             mem_read__ID_EX;
  logic             branch_taken__EX;
  logic             dmem_busy;
  logic             stat_clr;

  logic             pc_write;
  logic             enable__IF_ID;
  logic             enable_pipe;
  logic             flush__IF_ID;
  logic             flush__ID_EX;
  logic [CNT_W-1:0] stall_count;
  logic             state;

  modport slave (
    input  rs1__IF_ID, rs2__IF_ID, uses_rs1__IF_ID, uses_rs2__IF_ID,
           rd__ID_EX, mem_read__ID_EX, branch_taken__EX, dmem_busy, stat_clr,
    output pc_write, enable__IF_ID, enable_pipe, flush__IF_ID, flush__ID_EX,
           stall_count, state
  );

  modport master (
    output rs1__IF_ID, rs2__IF_ID, uses_rs1__IF_ID, uses_rs2__IF_ID,
           rd__ID_EX, mem_read__ID_EX, branch_taken__EX, dmem_busy, stat_clr,
    input  pc_write, enable__IF_ID, enable_pipe, flush__IF_ID, flush__ID_EX,
           stall_count, state
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller for a 5-stage in-order pipeline.
// Detects load-use hazards between IF/ID and ID/EX, inserts
// LOAD_STALL_CYCLES bubbles per hazard, flushes on taken branches and
// freezes the whole pipe while data memory is busy. Also keeps a
// saturating count of cycles in which the PC was held.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   arst_n - synchronous active-low reset
//   bus    - hazard_stall_controller_if.slave (hazard inputs, enables,
//            flushes, stall_count, state)
// Output priority: reset > dmem_busy > branch > load stall > normal.
module hazard_stall_controller #(
  parameter int REG_W             = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                            clk,
  input  logic                            arst_n,
  hazard_stall_controller_if.slave        bus
);

  typedef enum logic {RUN = 1'b0, LOAD_STALL = 1'b1} state_t;

  // The cycle that detects the hazard is the first bubble, so the FSM only
  // has to cover the remaining LOAD_STALL_CYCLES-1 cycles.
  localparam logic [1:0]       REM_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t           r_state;
  logic [1:0]       r_remaining;
  logic [CNT_W-1:0] r_stall_count;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_stalling;
  logic w_pc_write;
  logic w_en_if_id;
  logic w_en_pipe;
  logic w_flush_if_id;
  logic w_flush_id_ex;

  always_comb begin
    w_rs1_hit  = bus.uses_rs1__IF_ID && (bus.rs1__IF_ID == bus.rd__ID_EX);
    w_rs2_hit  = bus.uses_rs2__IF_ID && (bus.rs2__IF_ID == bus.rd__ID_EX);
    // x0 is hard-wired, so a load targeting it never creates a dependency.
    w_load_use = bus.mem_read__ID_EX && (bus.rd__ID_EX != '0) && (w_rs1_hit || w_rs2_hit);
    w_stalling = (r_state == LOAD_STALL) || w_load_use;
  end

  always_comb begin
    w_pc_write    = 1'b1;
    w_en_if_id    = 1'b1;
    w_en_pipe     = 1'b1;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    if (!arst_n) begin
      w_pc_write    = 1'b0;
      w_en_if_id    = 1'b0;
      w_en_pipe     = 1'b0;
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
    end else if (bus.dmem_busy) begin
      w_pc_write    = 1'b0;
      w_en_if_id    = 1'b0;
      w_en_pipe     = 1'b0;
    end else if (bus.branch_taken__EX) begin
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
    end else if (w_stalling) begin
      // Hold PC and IF/ID, let the load advance, bubble into ID/EX.
      w_pc_write    = 1'b0;
      w_en_if_id    = 1'b0;
      w_flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state       <= RUN;
      r_remaining   <= '0;
      r_stall_count <= '0;
    end else begin
      if (bus.stat_clr) begin
        r_stall_count <= '0;
      end else if (!w_pc_write) begin
        r_stall_count <= sat_inc(r_stall_count);
      end

      // A freeze holds state and remaining count, so it only stretches a stall.
      if (!bus.dmem_busy) begin
        if (bus.branch_taken__EX) begin
          r_state     <= RUN;
          r_remaining <= '0;
        end else if (r_state == LOAD_STALL) begin
          if (r_remaining <= 2'd1) begin
            r_state     <= RUN;
            r_remaining <= '0;
          end else begin
            r_remaining <= r_remaining - 2'd1;
          end
        end else if (w_load_use && (LOAD_STALL_CYCLES > 1)) begin
          r_state     <= LOAD_STALL;
          r_remaining <= REM_INIT;
        end
      end
    end
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.enable__IF_ID = w_en_if_id;
  assign bus.enable_pipe   = w_en_pipe;
  assign bus.flush__IF_ID  = w_flush_if_id;
  assign bus.flush__ID_EX  = w_flush_id_ex;
  assign bus.stall_count   = r_stall_count;
  assign bus.state         = (r_state == LOAD_STALL);

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Four instances share one
// stimulus: u1 (1 bubble), u2 (2 bubbles), u3 (3 bubbles), u4 (1 bubble,
// 2-bit counter). Output groups are packed as
// {pc_write, enable__IF_ID, enable_pipe, flush__IF_ID, flush__ID_EX}.
module tb_hazard_stall_controller;

  localparam logic [4:0] NORM  = 5'b11100;
  localparam logic [4:0] STALL = 5'b00101;
  localparam logic [4:0] FRZ   = 5'b00000;
  localparam logic [4:0] BR    = 5'b11111;
  localparam logic [4:0] RST   = 5'b00011;

  logic       clk;
  logic       arst_n;
  logic [4:0] rs1, rs2, rd;
  logic       us1, us2, mr, br, busy, clr;

  int checks = 0;
  int errors = 0;

  hazard_stall_controller_if #(.REG_W(5), .CNT_W(16)) i1 ();
  hazard_stall_controller_if #(.REG_W(5), .CNT_W(16)) i2 ();
  hazard_stall_controller_if #(.REG_W(5), .CNT_W(16)) i3 ();
  hazard_stall_controller_if #(.REG_W(5), .CNT_W(2))  i4 ();

  assign i1.rs1__IF_ID = rs1; assign i1.rs2__IF_ID = rs2; assign i1.rd__ID_EX = rd;
  assign i1.uses_rs1__IF_ID = us1; assign i1.uses_rs2__IF_ID = us2; assign i1.mem_read__ID_EX = mr;
  assign i1.branch_taken__EX = br; assign i1.dmem_busy = busy; assign i1.stat_clr = clr;
  assign i2.rs1__IF_ID = rs1; assign i2.rs2__IF_ID = rs2; assign i2.rd__ID_EX = rd;
  assign i2.uses_rs1__IF_ID = us1; assign i2.uses_rs2__IF_ID = us2; assign i2.mem_read__ID_EX = mr;
  assign i2.branch_taken__EX = br; assign i2.dmem_busy = busy; assign i2.stat_clr = clr;
  assign i3.rs1__IF_ID = rs1; assign i3.rs2__IF_ID = rs2; assign i3.rd__ID_EX = rd;
  assign i3.uses_rs1__IF_ID = us1; assign i3.uses_rs2__IF_ID = us2; assign i3.mem_read__ID_EX = mr;
  assign i3.branch_taken__EX = br; assign i3.dmem_busy = busy; assign i3.stat_clr = clr;
  assign i4.rs1__IF_ID = rs1; assign i4.rs2__IF_ID = rs2; assign i4.rd__ID_EX = rd;
  assign i4.uses_rs1__IF_ID = us1; assign i4.uses_rs2__IF_ID = us2; assign i4.mem_read__ID_EX = mr;
  assign i4.branch_taken__EX = br; assign i4.dmem_busy = busy; assign i4.stat_clr = clr;

  hazard_stall_controller #(.REG_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .arst_n(arst_n), .bus(i1.slave));
  hazard_stall_controller #(.REG_W(5), .LOAD_STALL_CYCLES(2), .CNT_W(16)) u2 (.clk(clk), .arst_n(arst_n), .bus(i2.slave));
  hazard_stall_controller #(.REG_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (.clk(clk), .arst_n(arst_n), .bus(i3.slave));
  hazard_stall_controller #(.REG_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(2))  u4 (.clk(clk), .arst_n(arst_n), .bus(i4.slave));

  wire [4:0] o1 = {i1.pc_write, i1.enable__IF_ID, i1.enable_pipe, i1.flush__IF_ID, i1.flush__ID_EX};
  wire [4:0] o2 = {i2.pc_write, i2.enable__IF_ID, i2.enable_pipe, i2.flush__IF_ID, i2.flush__ID_EX};
  wire [4:0] o3 = {i3.pc_write, i3.enable__IF_ID, i3.enable_pipe, i3.flush__IF_ID, i3.flush__ID_EX};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    us1 = 1'b0; us2 = 1'b0; mr = 1'b0;
    br = 1'b0; busy = 1'b0; clr = 1'b0;
  endtask

  task automatic haz();
    rs1 = 5'd5; rs2 = 5'd0; rd = 5'd5;
    us1 = 1'b1; us2 = 1'b0; mr = 1'b1;
  endtask

  task automatic stat_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    // Reset behaviour
    arst_n = 1'b0;
    idle();
    #1;
    chk("rst_out_u1", o1, RST);
    chk("rst_out_u3", o3, RST);
    tick();
    tick();
    chk("rst_state_u3", i3.state, 0);
    chk("rst_cnt_u1", i1.stall_count, 0);
    arst_n = 1'b1;
    #1;
    chk("norm_after_rst", o1, NORM);
    tick();

    // Single load-use hazard against 1/2/3 bubble variants
    haz();
    #1;
    chk("lu_c0_u1", o1, STALL);
    chk("lu_c0_u2", o2, STALL);
    chk("lu_c0_u3", o3, STALL);
    chk("lu_c0_state_u3", i3.state, 0);
    tick();
    idle();
    #1;
    chk("lu_cnt_u1", i1.stall_count, 1);
    chk("lu_c1_u1", o1, NORM);
    chk("lu_c1_u2", o2, STALL);
    chk("lu_c1_u3", o3, STALL);
    chk("lu_c1_state_u3", i3.state, 1);
    tick();
    #1;
    chk("lu_c2_u2", o2, NORM);
    chk("lu_c2_u3", o3, STALL);
    chk("lu_c2_state_u3", i3.state, 1);
    chk("lu_cnt_u2", i2.stall_count, 2);
    tick();
    #1;
    chk("lu_c3_u3", o3, NORM);
    chk("lu_c3_state_u3", i3.state, 0);
    chk("lu_cnt_u3", i3.stall_count, 3);
    chk("lu_cnt_u1_hold", i1.stall_count, 1);

    // No hazard through x0 or through an unused rs2
    mr = 1'b1; rd = 5'd0; rs1 = 5'd0; us1 = 1'b1;
    #1;
    chk("x0_u1", o1, NORM);
    chk("x0_u3", o3, NORM);
    rd = 5'd7; rs2 = 5'd7; us2 = 1'b0; rs1 = 5'd3; us1 = 1'b1;
    #1;
    chk("rs2_unused_u1", o1, NORM);
    us2 = 1'b1;
    #1;
    chk("rs2_used_u1", o1, STALL);
    tick();
    idle();
    tick();
    tick();

    // Freeze in the middle of a 2-cycle stall
    stat_clear();
    chk("clr_u2", i2.stall_count, 0);
    haz();
    #1;
    chk("frz_c0_u2", o2, STALL);
    tick();
    idle();
    busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("frz_out_u2", o2, FRZ);
      chk("frz_state_u2", i2.state, 1);
      tick();
    end
    busy = 1'b0;
    #1;
    chk("frz_resume_u2", o2, STALL);
    chk("frz_resume_state_u2", i2.state, 1);
    tick();
    #1;
    chk("frz_done_u2", o2, NORM);
    chk("frz_done_state_u2", i2.state, 0);
    chk("frz_cnt_u2", i2.stall_count, 6);
    chk("frz_cnt_u1", i1.stall_count, 5);
    tick();
    chk("frz_cnt_u3", i3.stall_count, 7);
    chk("frz_state_u3", i3.state, 0);

    // Branch wins over a pending load-use
    haz();
    br = 1'b1;
    #1;
    chk("br_lu_u1", o1, BR);
    chk("br_lu_u3", o3, BR);
    tick();
    chk("br_state_u2", i2.state, 0);
    chk("br_state_u3", i3.state, 0);
    idle();
    #1;
    chk("br_after_u3", o3, NORM);

    // Branch while in LOAD_STALL abandons the stall
    haz();
    tick();
    idle();
    #1;
    chk("brls_pre_state_u3", i3.state, 1);
    br = 1'b1;
    #1;
    chk("brls_out_u3", o3, BR);
    tick();
    br = 1'b0;
    #1;
    chk("brls_state_u3", i3.state, 0);
    chk("brls_norm_u3", o3, NORM);

    // Freeze wins over branch
    busy = 1'b1;
    br = 1'b1;
    #1;
    chk("frz_over_br_u1", o1, FRZ);
    idle();
    #1;

    // Saturation of a 2-bit counter, then clear during a stall
    stat_clear();
    haz();
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sat_cnt_u4", i4.stall_count, (k > 3) ? 3 : k);
    end
    chk("nosat_cnt_u1", i1.stall_count, 5);
    clr = 1'b1;
    #1;
    chk("clr_stall_u1", o1, STALL);
    tick();
    clr = 1'b0;
    chk("clr_over_inc_u4", i4.stall_count, 0);
    chk("clr_over_inc_u1", i1.stall_count, 0);
    idle();
    tick();
    tick();
    tick();

    // Reset in the middle of a stall
    haz();
    tick();
    idle();
    #1;
    chk("rstmid_pre_state_u3", i3.state, 1);
    arst_n = 1'b0;
    #1;
    chk("rstmid_out_u3", o3, RST);
    tick();
    chk("rstmid_state_u3", i3.state, 0);
    chk("rstmid_cnt_u3", i3.stall_count, 0);
    arst_n = 1'b1;
    #1;
    chk("rstmid_norm_u3", o3, NORM);
    tick();
    chk("rstmid_after_state_u3", i3.state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameter REG_W, default 5, width of register specifiers.
REQ-002 Parameter LOAD_STALL_CYCLES, default 1, legal range 1..3, number of bubble cycles inserted per load-use hazard.
REQ-003 Parameter CNT_W, default 16, width of the stall statistics counter.
REQ-004 The block SHALL use a single clock; reset is synchronous and active-low.
REQ-005 Port clk  input  1  clock; all state updates on its rising edge.
REQ-006 Port arst_n  input  1  reset, synchronous, active-low.
REQ-007 Port rs1__IF_ID, rs2__IF_ID  input  REG_W each  source specifiers of the instruction in IF/ID.
REQ-008 Port uses_rs1__IF_ID, uses_rs2__IF_ID  input  1 each  instruction in IF/ID actually reads rs1/rs2.
REQ-009 Port rd__ID_EX  input  REG_W  destination of the instruction in ID/EX.
REQ-010 Port mem_read__ID_EX  input  1  instruction in ID/EX is a load.
REQ-011 Port branch_taken__EX  input  1  taken branch/jump resolved in EX this cycle.
REQ-012 Port dmem_busy  input  1  data memory not ready; whole pipeline must freeze.
REQ-013 Port stat_clr  input  1  synchronous clear of stall_count.
REQ-014 Port pc_write  output  1  PC update enable.
REQ-015 Port enable__IF_ID  output  1  IF/ID register enable.
REQ-016 Port enable_pipe  output  1  enable for ID/EX, EX/MEM, MEM/WB registers.
REQ-017 Port flush__IF_ID, flush__ID_EX  output  1 each  insert bubble into that register.
REQ-018 Port stall_count  output  CNT_W  cycles with pc_write=0 since reset/clear.
REQ-019 Port state  output  1  FSM state, 0=RUN, 1=LOAD_STALL.

Function
REQ-020 load_use = mem_read__ID_EX and rd__ID_EX!=0 and ((uses_rs1__IF_ID and rs1__IF_ID==rd__ID_EX) or (uses_rs2__IF_ID and rs2__IF_ID==rd__ID_EX)); register 0 never causes a hazard.
REQ-021 Outputs SHALL be combinational from state, remaining-cycle counter and inputs; priority dmem_busy > branch_taken__EX > hazard/stall > normal.
REQ-022 Freeze (dmem_busy=1, any state): pc_write=0, enable__IF_ID=0, enable_pipe=0, both flushes 0; state and remaining counter hold.
REQ-023 Branch (not frozen, any state): pc_write=1, enable__IF_ID=1, enable_pipe=1, flush__IF_ID=1, flush__ID_EX=1; next state RUN, remaining counter cleared; pending load_use ignored.
REQ-024 RUN with load_use: pc_write=0, enable__IF_ID=0, enable_pipe=1, flush__ID_EX=1, flush__IF_ID=0; if LOAD_STALL_CYCLES>1 next state LOAD_STALL with remaining=LOAD_STALL_CYCLES-1, else stay RUN.
REQ-025 LOAD_STALL (no freeze/branch): same outputs as REQ-024 regardless of load_use; remaining decrements each cycle; when remaining==1 next state RUN.
REQ-026 RUN without hazard: pc_write=1, enable__IF_ID=1, enable_pipe=1, flushes 0.
REQ-027 Total bubbles per load-use hazard SHALL equal LOAD_STALL_CYCLES exactly, excluding freeze cycles, which extend but never shorten the stall.
REQ-028 stall_count increments by 1 on each clock edge where pc_write=0; saturates at 2^CNT_W-1 without wrapping.
REQ-029 stat_clr=1 sets stall_count to 0 at the next edge, overriding that cycle's increment.

Reset
REQ-030 While arst_n=0 at a rising edge: state<=RUN, remaining<=0, stall_count<=0.
REQ-031 While arst_n=0: pc_write=0, enable__IF_ID=0, enable_pipe=0, flush__IF_ID=1, flush__ID_EX=1; reset mid-stall abandons the stall.
REQ-032 First cycle after release: RUN behaviour per REQ-026/REQ-024.

Verification
REQ-033 LOAD_STALL_CYCLES=1, load rd=5, rs1=5 uses_rs1=1 -> one cycle pc_write=0, flush__ID_EX=1, then normal; stall_count=1.
REQ-034 LOAD_STALL_CYCLES=3, same hazard -> exactly 3 consecutive stall cycles, state 0,1,1 then 0; stall_count=3.
REQ-035 Load rd=0 with rs1=0, or rs2 match with uses_rs2=0 -> no stall, pc_write=1.
REQ-036 LOAD_STALL_CYCLES=2, dmem_busy=1 for 4 cycles in mid-stall -> all enables 0 for 4 cycles, stall resumes, 6 cycles total pc_write=0.
REQ-037 branch_taken__EX=1 together with load_use -> both flushes 1, pc_write=1, state RUN.
REQ-038 CNT_W=2, 5 stall cycles -> stall_count saturates at 3; stat_clr with stall same cycle -> 0.
